spu_fetch_ibuf: RTL and testbench

- Instruction line buffer and pair issuer between the local store's instruction-line port and the decode stage.
- Holds one 1024-bit line (32 instructions, 128 bytes) tagged with its line address.
- Issues one doubleword-aligned instruction pair (eins1 even word, eins2 odd word) per cycle and requests the next line when the PC leaves the buffered line.
- Supports decode stall and branch redirect.

---
 rtl/spu_fetch_ibuf.sv | 151 +++++++++++++++
 tb/tb_spu_fetch_ibuf.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_fetch_ibuf.sv
// Instruction line buffer and pair issuer between the local-store line port and decode.
//
// state | meaning
// IDLE  | after reset; moves straight to REQ
// REQ   | issues a line request for fpc's line on the next edge
// WAIT  | one request outstanding; waiting for line_valid
// RUN   | line buffered; issuing one instruction pair per cycle

module spu_fetch_ibuf #(
   parameter int unsigned       LINE_WD  = 1024,
   parameter int unsigned       INS_WD   = 32,
   parameter int unsigned       PC_WD    = 32,
   parameter logic [PC_WD-1:0]  RESET_PC = '0,
   parameter logic [INS_WD-1:0] NOP_INS  = 32'h4020_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_WD-1:0] cache_line,
   input  logic               line_valid,
   output logic               line_req,
   output logic [PC_WD-1:0]   line_addr,
   input  logic               dec_stall,
   input  logic               branch_taken,
   input  logic [PC_WD-1:0]   branch_pc,
   output logic [INS_WD-1:0]  eins1,
   output logic [INS_WD-1:0]  eins2,
   output logic               ins_valid,
   output logic [PC_WD-1:0]   pc_out
);

   localparam int unsigned N_WORDS = LINE_WD / INS_WD;
   localparam int unsigned OFF_WD  = $clog2(LINE_WD / 8);
   localparam int unsigned IDX_WD  = $clog2(N_WORDS);
   localparam int unsigned TAG_WD  = PC_WD - OFF_WD;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RUN} state_t;

   state_t               r_state;
   logic [PC_WD-1:0]     r_fpc;
   logic [TAG_WD-1:0]    r_tag;
   logic                 r_tag_valid;
   logic                 r_drop;
   logic [LINE_WD-1:0]   r_line;
   logic [INS_WD-1:0]    r_eins1;
   logic [INS_WD-1:0]    r_eins2;
   logic                 r_ins_valid;
   logic [PC_WD-1:0]     r_pc_out;
   logic                 r_line_req;
   logic [PC_WD-1:0]     r_line_addr;

   logic [INS_WD-1:0]    w_words [N_WORDS];
   logic [IDX_WD-1:0]    w_idx;
   logic [IDX_WD-1:0]    w_even_idx;
   logic [IDX_WD-1:0]    w_odd_idx;
   logic [PC_WD-1:0]     w_fpc_seq;
   logic [PC_WD-1:0]     w_br_pc;
   logic [PC_WD-1:0]     w_line_base;
   logic                 w_seq_in_line;
   logic                 w_br_in_line;

   for (genvar g = 0; g < N_WORDS; g++) begin : g_words
      assign w_words[g] = r_line[g*INS_WD +: INS_WD];
   end

   assign w_idx         = r_fpc[OFF_WD-1:2];
   assign w_even_idx    = {w_idx[IDX_WD-1:1], 1'b0};
   assign w_odd_idx     = {w_idx[IDX_WD-1:1], 1'b1};
   assign w_fpc_seq     = (r_fpc & ~PC_WD'(7)) + PC_WD'(8);
   assign w_br_pc       = branch_pc & ~PC_WD'(3);
   assign w_line_base   = {r_fpc[PC_WD-1:OFF_WD], {OFF_WD{1'b0}}};
   assign w_seq_in_line = (w_fpc_seq[PC_WD-1:OFF_WD] == r_tag);
   assign w_br_in_line  = r_tag_valid && (w_br_pc[PC_WD-1:OFF_WD] == r_tag);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_fpc       <= RESET_PC;
         r_tag       <= '0;
         r_tag_valid <= 1'b0;
         r_drop      <= 1'b0;
         r_line      <= '0;
         r_eins1     <= '0;
         r_eins2     <= '0;
         r_ins_valid <= 1'b0;
         r_pc_out    <= '0;
         r_line_req  <= 1'b0;
         r_line_addr <= '0;
      end else begin
         r_line_req <= 1'b0;
         if (branch_taken) begin
            r_fpc       <= w_br_pc;
            r_ins_valid <= 1'b0;
            unique case (r_state)
               S_RUN:   r_state <= w_br_in_line ? S_RUN : S_REQ;
               S_WAIT: begin
                  // a line landing in the same cycle is the stale one: drop it now
                  if (line_valid) begin
                     r_drop  <= 1'b0;
                     r_state <= S_REQ;
                  end else begin
                     r_drop  <= 1'b1;
                  end
               end
               default: r_state <= S_REQ;
            endcase
         end else begin
            if (!dec_stall) r_ins_valid <= 1'b0;
            unique case (r_state)
               S_IDLE: r_state <= S_REQ;
               S_REQ: begin
                  r_line_req  <= 1'b1;
                  r_line_addr <= w_line_base;
                  r_state     <= S_WAIT;
               end
               S_WAIT: begin
                  if (line_valid) begin
                     if (r_drop) begin
                        r_drop  <= 1'b0;
                        r_state <= S_REQ;
                     end else begin
                        r_line      <= cache_line;
                        r_tag       <= r_line_addr[PC_WD-1:OFF_WD];
                        r_tag_valid <= 1'b1;
                        r_state     <= S_RUN;
                     end
                  end
               end
               S_RUN: begin
                  if (!dec_stall) begin
                     r_eins1     <= w_idx[0] ? NOP_INS : w_words[w_even_idx];
                     r_eins2     <= w_words[w_odd_idx];
                     r_pc_out    <= r_fpc;
                     r_ins_valid <= 1'b1;
                     r_fpc       <= w_fpc_seq;
                     if (!w_seq_in_line) r_state <= S_REQ;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign line_req  = r_line_req;
   assign line_addr = r_line_addr;
   assign eins1     = r_eins1;
   assign eins2     = r_eins2;
   assign ins_valid = r_ins_valid;
   assign pc_out    = r_pc_out;

endmodule

// File: tb/tb_spu_fetch_ibuf.sv
// Bench for spu_fetch_ibuf: directed fetch scenarios followed by randomized
// stall/branch traffic, all checked against a pair-level reference model.

module tb_spu_fetch_ibuf;

   localparam logic [31:0] NOP = 32'h4020_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic [1023:0] cache_line = '0;
   logic          line_valid = 1'b0;
   logic          line_req;
   logic [31:0]   line_addr;
   logic          dec_stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [31:0]   branch_pc = '0;
   logic [31:0]   eins1, eins2, pc_out;
   logic          ins_valid;

   always #5 clk = ~clk;

   spu_fetch_ibuf #(
      .LINE_WD(1024), .INS_WD(32), .PC_WD(32),
      .RESET_PC(32'h0000_0000), .NOP_INS(NOP)
   ) dut (
      .clk(clk), .rst(rst), .cache_line(cache_line), .line_valid(line_valid),
      .line_req(line_req), .line_addr(line_addr), .dec_stall(dec_stall),
      .branch_taken(branch_taken), .branch_pc(branch_pc), .eins1(eins1),
      .eins2(eins2), .ins_valid(ins_valid), .pc_out(pc_out)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %08h required %08h at %0t", nm, act, exp, $time);
   endtask

   // Contents of local store: line 0 is the boot pattern, others are hashed.
   function automatic logic [31:0] line_word(input logic [31:0] a, input int i);
      logic [31:0] ln;
      ln = a >> 7;
      if (ln == 32'd0) return 32'h1000_0000 + 32'(i);
      return (ln * 32'h9E37_79B1) ^ (32'hA500_0000 + 32'(i));
   endfunction

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_REQ, M_WAIT, M_RUN} mphase_t;
   mphase_t     m_ph = M_IDLE;
   logic [31:0] m_pc = '0;
   logic [31:0] m_base = '0;
   logic [31:0] m_buf [32];
   bit          m_have = 0;
   bit          m_drop = 0;
   int          m_w;
   logic        e_iv = 0, e_req = 0;
   logic [31:0] e_e1 = '0, e_e2 = '0, e_pc = '0, e_addr = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ph = M_IDLE; m_pc = 32'h0; m_have = 0; m_drop = 0;
         e_iv = 0; e_req = 0; e_e1 = '0; e_e2 = '0; e_pc = '0; e_addr = '0;
      end else begin
         e_req = 0;
         if (branch_taken) begin
            m_pc = branch_pc & ~32'd3;
            e_iv = 0;
            if (m_ph == M_RUN)
               m_ph = (m_have && (m_pc / 128 == m_base / 128)) ? M_RUN : M_REQ;
            else if (m_ph == M_WAIT) begin
               if (line_valid) begin m_drop = 0; m_ph = M_REQ; end
               else m_drop = 1;
            end else m_ph = M_REQ;
         end else begin
            if (!dec_stall) e_iv = 0;
            case (m_ph)
               M_IDLE: m_ph = M_REQ;
               M_REQ: begin
                  e_req = 1; e_addr = m_pc - (m_pc % 128); m_ph = M_WAIT;
               end
               M_WAIT: if (line_valid) begin
                  if (m_drop) begin m_drop = 0; m_ph = M_REQ; end
                  else begin
                     for (int i = 0; i < 32; i++) m_buf[i] = line_word(e_addr, i);
                     m_base = e_addr; m_have = 1; m_ph = M_RUN;
                  end
               end
               M_RUN: if (!dec_stall) begin
                  m_w = int'((m_pc % 128) / 4);
                  if (m_w % 2 == 0) begin e_e1 = m_buf[m_w]; e_e2 = m_buf[m_w+1]; end
                  else begin e_e1 = NOP; e_e2 = m_buf[m_w]; end
                  e_pc = m_pc; e_iv = 1;
                  m_pc = m_pc - (m_pc % 8) + 32'd8;
                  if (m_pc / 128 != m_base / 128) m_ph = M_REQ;
               end
               default: m_ph = M_IDLE;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("line_req", 32'(line_req), 32'(e_req));
         chk("line_addr", line_addr, e_addr);
         chk("ins_valid", 32'(ins_valid), 32'(e_iv));
         if (e_iv) begin
            chk("eins1", eins1, e_e1);
            chk("eins2", eins2, e_e2);
            chk("pc_out", pc_out, e_pc);
         end
      end
   end

   // ---------------- local store responder and random driver ----------------
   bit          auto_mode = 0, rand_mode = 0, stray = 0, pend = 0;
   int          cnt = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] bases [5] = '{32'h0, 32'h80, 32'h200, 32'h400, 32'hFFFF_FF80};

   initial begin
      forever begin
         @(negedge clk);
         line_valid = 1'b0;
         if (rst !== 1'b1) pend = 0;
         else begin
            if (stray) begin
               line_valid = 1'b1; cache_line = {32{32'hDEAD_BEEF}}; stray = 0;
            end else if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  line_valid = 1'b1;
                  for (int i = 0; i < 32; i++) cache_line[32*i +: 32] = line_word(pend_addr, i);
                  pend = 0;
               end
            end
            if (line_req) begin
               pend = 1; pend_addr = line_addr;
               cnt = rand_mode ? int'($urandom_range(1, 4)) : 3;
            end
         end
         if (auto_mode) begin
            dec_stall = ($urandom_range(0, 99) < 25);
            branch_taken = 1'b0;
            if (!line_valid && $urandom_range(0, 99) < 5) begin
               branch_taken = 1'b1;
               case ($urandom_range(0, 2))
                  0: branch_pc = {m_pc[31:7], 7'($urandom_range(0, 127))};
                  1: branch_pc = bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 127));
                  default: branch_pc = $urandom;
               endcase
            end
         end
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic wait_req(input logic [31:0] addr, input int limit, input string nm);
      int k = 0;
      do begin @(negedge clk); k++; end while (line_req !== 1'b1 && k < limit);
      chk({nm, "_seen"}, 32'(line_req), 32'd1);
      chk({nm, "_addr"}, line_addr, addr);
   endtask

   task automatic wait_pair(input logic [31:0] pc, input int limit, input string nm);
      int k = 0;
      do begin @(negedge clk); k++; end while (!(ins_valid === 1'b1 && pc_out === pc) && k < limit);
      chk({nm, "_valid"}, 32'(ins_valid), 32'd1);
      chk({nm, "_pc"}, pc_out, pc);
   endtask

   initial begin
      int saw_iv;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ins_valid", 32'(ins_valid), 32'd0);
      chk("rst_line_req", 32'(line_req), 32'd0);
      chk("rst_line_addr", line_addr, 32'd0);
      chk("rst_eins1", eins1, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      rst = 1'b1;

      wait_req(32'h0, 10, "boot_req");
      repeat (4) @(negedge clk);
      chk("boot_latency", 32'(ins_valid), 32'd0);
      @(negedge clk);
      chk("boot_valid", 32'(ins_valid), 32'd1);
      chk("boot_pc", pc_out, 32'h0);
      chk("boot_eins1", eins1, 32'h1000_0000);
      chk("boot_eins2", eins2, 32'h1000_0001);

      wait_pair(32'h10, 10, "pre_stall");
      dec_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_valid", 32'(ins_valid), 32'd1);
         chk("stall_pc", pc_out, 32'h10);
         chk("stall_eins1", eins1, 32'h1000_0004);
         chk("stall_eins2", eins2, 32'h1000_0005);
      end
      dec_stall = 1'b0;
      @(negedge clk);
      chk("post_stall_pc", pc_out, 32'h18);

      wait_pair(32'h20, 10, "pre_odd");
      branch_taken = 1'b1; branch_pc = 32'h24;
      @(negedge clk);
      branch_taken = 1'b0;
      chk("odd_bubble", 32'(ins_valid), 32'd0);
      @(negedge clk);
      chk("odd_valid", 32'(ins_valid), 32'd1);
      chk("odd_eins1", eins1, 32'h4020_0000);
      chk("odd_eins2", eins2, 32'h1000_0009);
      chk("odd_pc", pc_out, 32'h24);
      @(negedge clk);
      chk("odd_next_pc", pc_out, 32'h28);

      wait_req(32'h80, 40, "seq_req");
      branch_taken = 1'b1; branch_pc = 32'h200;
      @(negedge clk);
      branch_taken = 1'b0;
      saw_iv = 0;
      for (int k = 0; k < 20 && line_req !== 1'b1; k++) begin
         if (ins_valid === 1'b1) saw_iv++;
         @(negedge clk);
      end
      chk("wait_br_no_valid", 32'(saw_iv), 32'd0);
      chk("wait_br_req", 32'(line_req), 32'd1);
      chk("wait_br_addr", line_addr, 32'h200);
      wait_pair(32'h200, 20, "line200");
      chk("line200_eins1", eins1, line_word(32'h200, 0));

      @(negedge clk);
      branch_taken = 1'b1; branch_pc = 32'h400;
      @(negedge clk);
      branch_taken = 1'b0;
      chk("far_bubble", 32'(ins_valid), 32'd0);
      wait_req(32'h400, 10, "far_req");
      wait_pair(32'h400, 20, "far");
      chk("far_eins1", eins1, line_word(32'h400, 0));
      chk("far_eins2", eins2, line_word(32'h400, 1));

      wait_pair(32'h418, 10, "pre_reset");
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_ins_valid", 32'(ins_valid), 32'd0);
      chk("arst_line_req", 32'(line_req), 32'd0);
      chk("arst_eins1", eins1, 32'd0);
      chk("arst_eins2", eins2, 32'd0);
      chk("arst_pc_out", pc_out, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      stray = 1;
      wait_req(32'h0, 10, "arst_req");
      wait_pair(32'h0, 20, "arst_boot");
      chk("arst_boot_eins1", eins1, 32'h1000_0000);

      rand_mode = 1;
      auto_mode = 1;
      repeat (3000) @(negedge clk);
      auto_mode = 0;
      branch_taken = 1'b0;
      dec_stall = 1'b0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
